// File: rtl/ballot_collector.sv
// Ballot collection front end for the 5-voter majority stage: takes one
// validated ballot per cycle, stores it per voter and closes on 5 ballots or timeout.
module ballot_collector #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          ALLOW_ABSTAIN  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ballot_valid,
  output logic       ballot_ready,
  input  logic [2:0] ballot_id,
  input  logic [2:0] ballot_choice,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic [2:0] C,
  output logic [2:0] D,
  output logic [2:0] E,
  output logic [2:0] count,
  output logic       ballots_done,
  output logic       timed_out,
  output logic       reject,
  output logic [1:0] reject_code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CLOSED  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [2:0]      r_votes [5];
  logic [4:0]      r_mask;
  logic [2:0]      r_count;
  logic [TW-1:0]   r_timer;
  logic            r_ready;
  logic            r_done;
  logic            r_timed_out;
  logic            r_reject;
  logic [1:0]      r_reject_code;

  logic            w_xfer;
  logic            w_bad_id;
  logic            w_bad_choice;
  logic            w_dup;
  logic            w_accept;
  logic            w_refuse;
  logic [1:0]      w_code;
  logic            w_clear;
  logic            w_close_timeout;

  // Ballot validation; the priority of the failure codes follows the check order.
  always_comb begin
    w_xfer       = ballot_valid & r_ready;
    w_bad_id     = (ballot_id > 3'd4);
    w_bad_choice = !((ballot_choice == 3'b001) || (ballot_choice == 3'b010) ||
                     (ballot_choice == 3'b100) ||
                     (ALLOW_ABSTAIN && (ballot_choice == 3'b000)));
    w_dup = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (ballot_id == 3'(i) && r_mask[i]) begin
        w_dup = 1'b1;
      end
    end
    w_accept = w_xfer & !w_bad_id & !w_bad_choice & !w_dup;
    w_refuse = w_xfer & !w_accept;
    if (w_bad_id) begin
      w_code = 2'b01;
    end else if (w_bad_choice) begin
      w_code = 2'b10;
    end else begin
      w_code = 2'b11;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_clear         = 1'b0;
    w_close_timeout = 1'b0;
    case (r_state)
      IDLE, CLOSED: begin
        if (start) begin
          w_next_state = COLLECT;
          w_clear      = 1'b1;
        end
      end
      COLLECT: begin
        // A fifth accepted ballot wins over a coinciding timeout.
        if (w_accept && (r_count == 3'd4)) begin
          w_next_state = CLOSED;
        end else if (r_timer == TIMER_LAST) begin
          w_next_state    = CLOSED;
          w_close_timeout = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_mask        <= '0;
      r_count       <= '0;
      r_timer       <= '0;
      r_ready       <= 1'b0;
      r_done        <= 1'b0;
      r_timed_out   <= 1'b0;
      r_reject      <= 1'b0;
      r_reject_code <= 2'b00;
      for (int i = 0; i < 5; i++) begin
        r_votes[i] <= 3'b000;
      end
    end else begin
      r_state  <= w_next_state;
      r_ready  <= (w_next_state == COLLECT);
      r_done   <= (w_next_state == CLOSED);
      r_reject <= w_refuse;
      if (w_refuse) begin
        r_reject_code <= w_code;
      end
      if (w_clear) begin
        r_mask      <= '0;
        r_count     <= '0;
        r_timer     <= '0;
        r_timed_out <= 1'b0;
        for (int i = 0; i < 5; i++) begin
          r_votes[i] <= 3'b000;
        end
      end else if (r_state == COLLECT) begin
        for (int i = 0; i < 5; i++) begin
          if (w_accept && (ballot_id == 3'(i))) begin
            r_votes[i] <= ballot_choice;
            r_mask[i]  <= 1'b1;
          end
        end
        if (w_accept) begin
          r_count <= r_count + 3'd1;
        end
        if (r_timer != TIMER_MAX) begin
          r_timer <= r_timer + TIMER_ONE;
        end
        if (w_close_timeout) begin
          r_timed_out <= 1'b1;
        end
      end
    end
  end

  assign ballot_ready = r_ready;
  assign A            = r_votes[0];
  assign B            = r_votes[1];
  assign C            = r_votes[2];
  assign D            = r_votes[3];
  assign E            = r_votes[4];
  assign count        = r_count;
  assign ballots_done = r_done;
  assign timed_out    = r_timed_out;
  assign reject       = r_reject;
  assign reject_code  = r_reject_code;

endmodule

// File: tb/tb_ballot_collector.sv
// Scoreboard bench for ballot_collector: three instances with different
// timeout/abstain settings, reject and close events checked against a queue.
module tb_ballot_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start [3];
  logic       bvalid [3];
  logic [2:0] bid [3];
  logic [2:0] bch [3];
  logic       ready [3];
  logic       done [3];
  logic       tmo [3];
  logic       rej [3];
  logic [1:0] rcode [3];
  logic [2:0] oa [3];
  logic [2:0] ob [3];
  logic [2:0] oc [3];
  logic [2:0] od [3];
  logic [2:0] oe [3];
  logic [2:0] cnt [3];
  logic       prevDone [3];

  typedef struct {
    int         inst;
    bit         isClose;
    logic [1:0] code;
    logic [14:0] votes;
    logic [2:0] count;
    logic       timedOut;
  } ev_t;

  ev_t expQ[$];
  int checks = 0;
  int errors = 0;

  ballot_collector #(.TIMEOUT_CYCLES(255), .ALLOW_ABSTAIN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .ballot_valid(bvalid[0]),
    .ballot_ready(ready[0]), .ballot_id(bid[0]), .ballot_choice(bch[0]),
    .A(oa[0]), .B(ob[0]), .C(oc[0]), .D(od[0]), .E(oe[0]), .count(cnt[0]),
    .ballots_done(done[0]), .timed_out(tmo[0]), .reject(rej[0]), .reject_code(rcode[0])
  );

  ballot_collector #(.TIMEOUT_CYCLES(8), .ALLOW_ABSTAIN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .ballot_valid(bvalid[1]),
    .ballot_ready(ready[1]), .ballot_id(bid[1]), .ballot_choice(bch[1]),
    .A(oa[1]), .B(ob[1]), .C(oc[1]), .D(od[1]), .E(oe[1]), .count(cnt[1]),
    .ballots_done(done[1]), .timed_out(tmo[1]), .reject(rej[1]), .reject_code(rcode[1])
  );

  ballot_collector #(.TIMEOUT_CYCLES(5), .ALLOW_ABSTAIN(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .ballot_valid(bvalid[2]),
    .ballot_ready(ready[2]), .ballot_id(bid[2]), .ballot_choice(bch[2]),
    .A(oa[2]), .B(ob[2]), .C(oc[2]), .D(od[2]), .E(oe[2]), .count(cnt[2]),
    .ballots_done(done[2]), .timed_out(tmo[2]), .reject(rej[2]), .reject_code(rcode[2])
  );

  function automatic logic [14:0] votesOf(int i);
    return {oa[i], ob[i], oc[i], od[i], oe[i]};
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic handleEvent(int i, bit isClose);
    ev_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpectedEvent: inst %0d close=%0d code=%b with empty queue",
               i, isClose, rcode[i]);
    end else begin
      e = expQ.pop_front();
      if (e.inst != i || e.isClose != isClose) begin
        errors++;
        $display("[TB] FAIL eventKind: got inst %0d close=%0d, expected inst %0d close=%0d",
                 i, isClose, e.inst, e.isClose);
      end else if (!isClose && rcode[i] !== e.code) begin
        errors++;
        $display("[TB] FAIL rejectCode inst %0d: got %b, expected %b", i, rcode[i], e.code);
      end else if (isClose && {votesOf(i), cnt[i], tmo[i]} !== {e.votes, e.count, e.timedOut}) begin
        errors++;
        $display("[TB] FAIL closeState inst %0d: got votes %b count %0d to %b, expected votes %b count %0d to %b",
                 i, votesOf(i), cnt[i], tmo[i], e.votes, e.count, e.timedOut);
      end
    end
  endtask

  // Monitor: every reject pulse and every rising ballots_done pops one expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rej[i] === 1'b1) handleEvent(i, 1'b0);
      if (done[i] === 1'b1 && prevDone[i] !== 1'b1) handleEvent(i, 1'b1);
      prevDone[i] <= done[i];
    end
  end

  task automatic pushReject(int i, logic [1:0] code);
    ev_t e;
    e.inst = i; e.isClose = 1'b0; e.code = code;
    e.votes = '0; e.count = '0; e.timedOut = 1'b0;
    expQ.push_back(e);
  endtask

  task automatic pushClose(int i, logic [14:0] votes, logic [2:0] count, logic to);
    ev_t e;
    e.inst = i; e.isClose = 1'b1; e.code = 2'b00;
    e.votes = votes; e.count = count; e.timedOut = to;
    expQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of stimulus on one instance; returns 1 time unit after the consuming edge.
  task automatic applyStimulus(int i, logic s, logic v, logic [2:0] id, logic [2:0] ch);
    start[i]  = s;
    bvalid[i] = v;
    bid[i]    = id;
    bch[i]    = ch;
    tick();
    start[i]  = 1'b0;
    bvalid[i] = 1'b0;
    bid[i]    = 3'd0;
    bch[i]    = 3'd0;
  endtask

  task automatic waitDone(int i, inout int n);
    while (done[i] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks + 1, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; bvalid[i] = 1'b0; bid[i] = 3'd0; bch[i] = 3'd0; prevDone[i] = 1'b0;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset%0d", i),
                  {ready[i], done[i], tmo[i], rej[i], rcode[i], cnt[i], votesOf(i)}, 32'd0);
    end
    rst_n = 1'b1;
    tick();

    $display("[TB] five ballots back to back");
    applyStimulus(0, 1'b1, 1'b0, 3'd0, 3'd0);
    checkOutput("t1_readyAfterStart", {ready[0], cnt[0]}, {1'b1, 3'd0});
    pushClose(0, 15'b001_010_100_100_001, 3'd5, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 3'd0, 3'b001);
    checkOutput("t1_countAfterFirst", cnt[0], 3'd1);
    applyStimulus(0, 1'b0, 1'b1, 3'd1, 3'b010);
    applyStimulus(0, 1'b0, 1'b1, 3'd2, 3'b100);
    applyStimulus(0, 1'b0, 1'b1, 3'd3, 3'b100);
    applyStimulus(0, 1'b0, 1'b1, 3'd4, 3'b001);
    checkOutput("t1_closed", {done[0], ready[0], tmo[0], cnt[0]}, {1'b1, 1'b0, 1'b0, 3'd5});

    $display("[TB] refused ballots");
    applyStimulus(0, 1'b1, 1'b0, 3'd0, 3'd0);
    checkOutput("t2_cleared", {done[0], ready[0], cnt[0], votesOf(0)}, {1'b0, 1'b1, 18'd0});
    pushReject(0, 2'b10);
    applyStimulus(0, 1'b0, 1'b1, 3'd2, 3'b011);
    pushReject(0, 2'b01);
    applyStimulus(0, 1'b0, 1'b1, 3'd6, 3'b001);
    applyStimulus(0, 1'b0, 1'b1, 3'd1, 3'b010);
    pushReject(0, 2'b11);
    applyStimulus(0, 1'b0, 1'b1, 3'd1, 3'b010);
    tick();
    checkOutput("t2_rejectHeld", {rej[0], rcode[0]}, {1'b0, 2'b11});
    pushReject(0, 2'b10);
    applyStimulus(0, 1'b0, 1'b1, 3'd3, 3'b000);
    applyStimulus(0, 1'b1, 1'b0, 3'd0, 3'd0);
    checkOutput("t2_startIgnored", {ready[0], cnt[0], votesOf(0)},
                {1'b1, 3'd1, 15'b000_010_000_000_000});

    $display("[TB] reset during collection");
    applyStimulus(0, 1'b0, 1'b1, 3'd0, 3'b100);
    applyStimulus(0, 1'b0, 1'b1, 3'd2, 3'b001);
    checkOutput("t5_countBeforeReset", cnt[0], 3'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("t5_afterReset", {ready[0], done[0], cnt[0], votesOf(0)}, 20'd0);
    applyStimulus(0, 1'b0, 1'b1, 3'd0, 3'b001);
    checkOutput("t5_noHandshake", {rej[0], cnt[0], ready[0]}, 5'd0);

    $display("[TB] timeout close");
    applyStimulus(1, 1'b1, 1'b0, 3'd0, 3'd0);
    pushClose(1, 15'b100_000_000_010_000, 3'd2, 1'b1);
    applyStimulus(1, 1'b0, 1'b1, 3'd0, 3'b100);
    applyStimulus(1, 1'b0, 1'b1, 3'd3, 3'b010);
    n = 2;
    waitDone(1, n);
    checkOutput("t3_closeCycle", n, 8);
    checkOutput("t3_flags", {ready[1], tmo[1], cnt[1]}, {1'b0, 1'b1, 3'd2});

    $display("[TB] abstention and restart");
    applyStimulus(1, 1'b1, 1'b0, 3'd0, 3'd0);
    checkOutput("t6_restartClears", {ready[1], done[1], tmo[1], cnt[1], votesOf(1)}, {1'b1, 20'd0});
    applyStimulus(1, 1'b0, 1'b1, 3'd4, 3'b000);
    checkOutput("t6_abstainAccepted", {rej[1], cnt[1], oe[1]}, {1'b0, 3'd1, 3'b000});
    pushReject(1, 2'b11);
    applyStimulus(1, 1'b0, 1'b1, 3'd4, 3'b001);
    pushClose(1, 15'd0, 3'd1, 1'b1);
    n = 2;
    waitDone(1, n);
    checkOutput("t6_timeoutCycle", n, 8);

    $display("[TB] fifth ballot on the timeout edge");
    applyStimulus(2, 1'b1, 1'b0, 3'd0, 3'd0);
    pushClose(2, 15'b010_001_100_010_100, 3'd5, 1'b0);
    applyStimulus(2, 1'b0, 1'b1, 3'd0, 3'b010);
    applyStimulus(2, 1'b0, 1'b1, 3'd1, 3'b001);
    applyStimulus(2, 1'b0, 1'b1, 3'd2, 3'b100);
    applyStimulus(2, 1'b0, 1'b1, 3'd3, 3'b010);
    checkOutput("t4_stillCollecting", {ready[2], done[2], cnt[2]}, {1'b1, 1'b0, 3'd4});
    applyStimulus(2, 1'b0, 1'b1, 3'd4, 3'b100);
    checkOutput("t4_closedByCount", {done[2], tmo[2], cnt[2]}, {1'b1, 1'b0, 3'd5});

    tick();
    tick();
    checkOutput("pendingEvents", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
